// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: shares one system-bus port between I-cache (m0) and D-cache (m1).
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise m1 always wins.
module cache_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_readAddr_valid,
  output logic              m0_readAddr_ready,
  input  logic [ADDR_W-1:0] m0_readAddr,
  output logic              m0_readData_valid,
  input  logic              m0_readData_ready,
  output logic [DATA_W-1:0] m0_readData,
  input  logic              m0_writeAddr_valid,
  output logic              m0_writeAddr_ready,
  input  logic              m0_writeData_valid,
  output logic              m0_writeData_ready,
  input  logic [ADDR_W-1:0] m0_writeAddr,
  input  logic [DATA_W-1:0] m0_writeData,
  input  logic [3:0]        m0_writeStrb,
  output logic              m0_writeResp_valid,
  input  logic              m0_writeResp_ready,
  output logic [31:0]       m0_writeResp_msg,
  input  logic              m1_readAddr_valid,
  output logic              m1_readAddr_ready,
  input  logic [ADDR_W-1:0] m1_readAddr,
  output logic              m1_readData_valid,
  input  logic              m1_readData_ready,
  output logic [DATA_W-1:0] m1_readData,
  input  logic              m1_writeAddr_valid,
  output logic              m1_writeAddr_ready,
  input  logic              m1_writeData_valid,
  output logic              m1_writeData_ready,
  input  logic [ADDR_W-1:0] m1_writeAddr,
  input  logic [DATA_W-1:0] m1_writeData,
  input  logic [3:0]        m1_writeStrb,
  output logic              m1_writeResp_valid,
  input  logic              m1_writeResp_ready,
  output logic [31:0]       m1_writeResp_msg,
  output logic              s_readAddr_valid,
  input  logic              s_readAddr_ready,
  output logic [ADDR_W-1:0] s_readAddr,
  input  logic              s_readData_valid,
  output logic              s_readData_ready,
  input  logic [DATA_W-1:0] s_readData,
  output logic              s_writeAddr_valid,
  input  logic              s_writeAddr_ready,
  output logic              s_writeData_valid,
  input  logic              s_writeData_ready,
  output logic [ADDR_W-1:0] s_writeAddr,
  output logic [DATA_W-1:0] s_writeData,
  output logic [3:0]        s_writeStrb,
  input  logic              s_writeResp_valid,
  output logic              s_writeResp_ready,
  input  logic [31:0]       s_writeResp_msg,
  output logic              arb_grant,
  output logic              arb_busy
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP
  } state_e;

  state_e state_q;
  logic   grant_q;
  logic   wreq0, wreq1, req0, req1;
  logic   win, win_wr;
  logic   ra_rdy, rd_vld, w_rdy, wr_vld;

  logic              o_ra_valid, o_wa_valid, o_wd_valid;
  logic              o_rd_ready, o_wr_ready;
  logic [ADDR_W-1:0] o_ra, o_wa;
  logic [DATA_W-1:0] o_wd;
  logic [3:0]        o_strb;

  assign wreq0 = m0_writeAddr_valid & m0_writeData_valid;
  assign wreq1 = m1_writeAddr_valid & m1_writeData_valid;
  assign req0  = wreq0 | m0_readAddr_valid;
  assign req1  = wreq1 | m1_readAddr_valid;

  assign o_ra_valid = grant_q ? m1_readAddr_valid  : m0_readAddr_valid;
  assign o_wa_valid = grant_q ? m1_writeAddr_valid : m0_writeAddr_valid;
  assign o_wd_valid = grant_q ? m1_writeData_valid : m0_writeData_valid;
  assign o_rd_ready = grant_q ? m1_readData_ready  : m0_readData_ready;
  assign o_wr_ready = grant_q ? m1_writeResp_ready : m0_writeResp_ready;
  assign o_ra       = grant_q ? m1_readAddr  : m0_readAddr;
  assign o_wa       = grant_q ? m1_writeAddr : m0_writeAddr;
  assign o_wd       = grant_q ? m1_writeData : m0_writeData;
  assign o_strb     = grant_q ? m1_writeStrb : m0_writeStrb;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;
  assign win = (req0 & req1) ? ~last_grant_q : req1;
`else
  assign win = req1;
`endif
  assign win_wr = win ? wreq1 : wreq0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (req0 | req1) begin
          grant_q      <= win;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_q <= win;
`endif
          state_q      <= win_wr ? WR_ADDR : RD_ADDR;
        end
        RD_ADDR: if (o_ra_valid & s_readAddr_ready) state_q <= RD_DATA;
        RD_DATA: if (s_readData_valid & o_rd_ready) state_q <= IDLE;
        WR_ADDR: if (o_wa_valid & o_wd_valid & w_rdy) state_q <= WR_RESP;
        WR_RESP: if (s_writeResp_valid & o_wr_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Only the current phase's handshake is routed; all others stay low.
  always_comb begin
    s_readAddr_valid  = 1'b0;
    s_readData_ready  = 1'b0;
    s_writeAddr_valid = 1'b0;
    s_writeData_valid = 1'b0;
    s_writeResp_ready = 1'b0;
    ra_rdy = 1'b0;
    rd_vld = 1'b0;
    w_rdy  = 1'b0;
    wr_vld = 1'b0;
    unique case (state_q)
      RD_ADDR: begin
        s_readAddr_valid = o_ra_valid;
        ra_rdy           = s_readAddr_ready;
      end
      RD_DATA: begin
        s_readData_ready = o_rd_ready;
        rd_vld           = s_readData_valid;
      end
      WR_ADDR: begin
        s_writeAddr_valid = o_wa_valid;
        s_writeData_valid = o_wd_valid;
        w_rdy             = s_writeAddr_ready & s_writeData_ready;
      end
      WR_RESP: begin
        s_writeResp_ready = o_wr_ready;
        wr_vld            = s_writeResp_valid;
      end
      default: ;
    endcase
  end

  assign m0_readAddr_ready  = ra_rdy & ~grant_q;
  assign m1_readAddr_ready  = ra_rdy &  grant_q;
  assign m0_readData_valid  = rd_vld & ~grant_q;
  assign m1_readData_valid  = rd_vld &  grant_q;
  assign m0_writeAddr_ready = w_rdy  & ~grant_q;
  assign m1_writeAddr_ready = w_rdy  &  grant_q;
  assign m0_writeData_ready = w_rdy  & ~grant_q;
  assign m1_writeData_ready = w_rdy  &  grant_q;
  assign m0_writeResp_valid = wr_vld & ~grant_q;
  assign m1_writeResp_valid = wr_vld &  grant_q;

  assign s_readAddr  = o_ra;
  assign s_writeAddr = o_wa;
  assign s_writeData = o_wd;
  assign s_writeStrb = o_strb;

  assign m0_readData      = s_readData;
  assign m1_readData      = s_readData;
  assign m0_writeResp_msg = s_writeResp_msg;
  assign m1_writeResp_msg = s_writeResp_msg;

  assign arb_grant = grant_q;
  assign arb_busy  = (state_q != IDLE);

endmodule
